// File: rtl/wb_sdrc_arbiter.sv
// Two-master Wishbone arbiter in front of a single SDRAM controller port.
// Round-robin on ties, burst lock while the granted cyc is held, stall timeout with err.
module wb_sdrc_arbiter #(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,

  input  logic            m0_wb_cyc_i,
  input  logic            m0_wb_stb_i,
  input  logic            m0_wb_we_i,
  input  logic [DW/8-1:0] m0_wb_sel_i,
  input  logic [AW-1:0]   m0_wb_adr_i,
  input  logic [DW-1:0]   m0_wb_dat_i,
  output logic [DW-1:0]   m0_wb_dat_o,
  output logic            m0_wb_ack_o,
  output logic            m0_wb_err_o,

  input  logic            m1_wb_cyc_i,
  input  logic            m1_wb_stb_i,
  input  logic            m1_wb_we_i,
  input  logic [DW/8-1:0] m1_wb_sel_i,
  input  logic [AW-1:0]   m1_wb_adr_i,
  input  logic [DW-1:0]   m1_wb_dat_i,
  output logic [DW-1:0]   m1_wb_dat_o,
  output logic            m1_wb_ack_o,
  output logic            m1_wb_err_o,

  output logic            s_wb_cyc_o,
  output logic            s_wb_stb_o,
  output logic            s_wb_we_o,
  output logic [DW/8-1:0] s_wb_sel_o,
  output logic [AW-1:0]   s_wb_adr_o,
  output logic [DW-1:0]   s_wb_dat_o,
  input  logic [DW-1:0]   s_wb_dat_i,
  input  logic            s_wb_ack_i,

  output logic [1:0]      grant_o,
  output logic            busy_o
);

  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t      state, state_nxt;
  logic        last_grant, last_grant_nxt;
  logic [15:0] stall_cnt, stall_cnt_nxt;

  logic        gnt_cyc;
  logic        gnt_stb;
  logic        timeout;
  logic        ack_ok;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      stall_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      stall_cnt  <= stall_cnt_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    gnt_cyc    = 1'b0;
    gnt_stb    = 1'b0;
    s_wb_we_o  = 1'b0;
    s_wb_sel_o = '0;
    s_wb_adr_o = '0;
    s_wb_dat_o = '0;
    unique case (state)
      GNT0: begin
        gnt_cyc    = m0_wb_cyc_i;
        gnt_stb    = m0_wb_cyc_i & m0_wb_stb_i;
        s_wb_we_o  = m0_wb_we_i;
        s_wb_sel_o = m0_wb_sel_i;
        s_wb_adr_o = m0_wb_adr_i;
        s_wb_dat_o = m0_wb_dat_i;
      end
      GNT1: begin
        gnt_cyc    = m1_wb_cyc_i;
        gnt_stb    = m1_wb_cyc_i & m1_wb_stb_i;
        s_wb_we_o  = m1_wb_we_i;
        s_wb_sel_o = m1_wb_sel_i;
        s_wb_adr_o = m1_wb_adr_i;
        s_wb_dat_o = m1_wb_dat_i;
      end
      default: ;
    endcase
  end

  // An ack landing on the terminal stall cycle wins over the timeout.
  assign timeout    = gnt_stb & ~s_wb_ack_i & (stall_cnt == TIMEOUT_VAL);
  assign ack_ok     = gnt_stb & s_wb_ack_i;
  assign s_wb_cyc_o = gnt_cyc & ~timeout;
  assign s_wb_stb_o = gnt_stb & ~timeout;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) state_nxt = last_grant ? GNT0 : GNT1;
        else if (m0_wb_cyc_i)           state_nxt = GNT0;
        else if (m1_wb_cyc_i)           state_nxt = GNT1;
      end
      GNT0: if (!m0_wb_cyc_i || timeout) state_nxt = m1_wb_cyc_i ? GNT1 : IDLE;
      GNT1: if (!m1_wb_cyc_i || timeout) state_nxt = m0_wb_cyc_i ? GNT0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    last_grant_nxt = last_grant;
    if (state_nxt == GNT0)      last_grant_nxt = 1'b0;
    else if (state_nxt == GNT1) last_grant_nxt = 1'b1;
  end

  // Counter tracks consecutive stalled strobes of the current grant only.
  always_comb begin
    if (state_nxt != state || !s_wb_stb_o || s_wb_ack_i) stall_cnt_nxt = '0;
    else                                                  stall_cnt_nxt = stall_cnt + 16'd1;
  end

  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;
  assign m0_wb_ack_o = (state == GNT0) & ack_ok;
  assign m1_wb_ack_o = (state == GNT1) & ack_ok;
  assign m0_wb_err_o = (state == GNT0) & timeout;
  assign m1_wb_err_o = (state == GNT1) & timeout;

  assign grant_o = state;
  assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_wb_sdrc_arbiter.sv
// Self-checking bench for wb_sdrc_arbiter (TIMEOUT=4); read data and ack routing
// are checked through a scoreboard, control behaviour through directed checks.
module tb_wb_sdrc_arbiter;

  localparam int AW = 26;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;

  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]    m0_sel, m1_sel;
  logic [AW-1:0] m0_adr, m1_adr;
  logic [DW-1:0] m0_dat, m1_dat, m0_rdat, m1_rdat;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          s_cyc, s_stb, s_we, s_ack;
  logic [3:0]    s_sel;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat, s_rdat;
  logic [1:0]    grant;
  logic          busy;

  typedef struct {
    int          master;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_sdrc_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .m0_wb_cyc_i (m0_cyc), .m0_wb_stb_i (m0_stb), .m0_wb_we_i (m0_we),
    .m0_wb_sel_i (m0_sel), .m0_wb_adr_i (m0_adr), .m0_wb_dat_i (m0_dat),
    .m0_wb_dat_o (m0_rdat), .m0_wb_ack_o (m0_ack), .m0_wb_err_o (m0_err),
    .m1_wb_cyc_i (m1_cyc), .m1_wb_stb_i (m1_stb), .m1_wb_we_i (m1_we),
    .m1_wb_sel_i (m1_sel), .m1_wb_adr_i (m1_adr), .m1_wb_dat_i (m1_dat),
    .m1_wb_dat_o (m1_rdat), .m1_wb_ack_o (m1_ack), .m1_wb_err_o (m1_err),
    .s_wb_cyc_o  (s_cyc), .s_wb_stb_o (s_stb), .s_wb_we_o (s_we),
    .s_wb_sel_o  (s_sel), .s_wb_adr_o (s_adr), .s_wb_dat_o (s_wdat),
    .s_wb_dat_i  (s_rdat), .s_wb_ack_i (s_ack),
    .grant_o     (grant),
    .busy_o      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_drive(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_sel = 4'hF; m0_adr = adr; m0_dat = dat;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_sel = 4'hF; m1_adr = adr; m1_dat = dat;
    end
  endtask

  // Scoreboard monitor: every ack must match the oldest outstanding transfer.
  always @(negedge clk) begin
    if (!rst && (m0_ack || m1_ack)) begin
      check("ack_both", {m0_ack, m1_ack} == 2'b11, 1'b0);
      if (sb.size() == 0) begin
        check("ack_unexpected", 1'b1, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check("ack_master", m1_ack ? 1 : 0, mon_e.master);
        check("ack_data", m1_ack ? m1_rdat : m0_rdat, mon_e.data);
      end
    end
  end

  initial begin
    rst = 1'b1;
    s_ack = 1'b0;
    s_rdat = '0;
    m_drive(0, 0, 0, 0, '0, '0);
    m_drive(1, 0, 0, 0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_s_cyc", s_cyc, 1'b0);
    check("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0);
    rst = 1'b0;

    // Single master write.
    tick();
    m_drive(0, 1, 1, 1, 26'h10, 32'hA5A5A5A5);
    sb.push_back('{0, 32'h0});
    @(negedge clk);
    check("t1_idle_s_cyc", s_cyc, 1'b0);
    tick();
    s_ack = 1'b1;
    @(negedge clk);
    check("t1_grant", grant, 2'b01);
    check("t1_s_cyc", s_cyc, 1'b1);
    check("t1_s_we", s_we, 1'b1);
    check("t1_s_adr", s_adr, 26'h10);
    check("t1_s_dat", s_wdat, 32'hA5A5A5A5);
    check("t1_m0_ack", m0_ack, 1'b1);
    check("t1_m1_ack", m1_ack, 1'b0);
    tick();
    s_ack = 1'b0;
    m_drive(0, 0, 0, 0, '0, '0);
    @(negedge clk);
    check("t1_drop_s_cyc", s_cyc, 1'b0);
    tick();
    @(negedge clk);
    check("t1_idle_grant", grant, 2'b00);
    check("t1_idle_busy", busy, 1'b0);

    // Tie right after reset goes to m0, then straight to m1.
    tick();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_drive(0, 1, 1, 0, 26'h20, '0);
    m_drive(1, 1, 1, 0, 26'h24, '0);
    sb.push_back('{0, 32'h11110000});
    sb.push_back('{1, 32'h22220000});
    tick();
    s_rdat = 32'h11110000;
    s_ack = 1'b1;
    @(negedge clk);
    check("t2_tie_grant", grant, 2'b01);
    tick();
    s_ack = 1'b0;
    m_drive(0, 0, 0, 0, '0, '0);
    @(negedge clk);
    check("t2_drop_s_cyc", s_cyc, 1'b0);
    tick();
    s_rdat = 32'h22220000;
    s_ack = 1'b1;
    @(negedge clk);
    check("t2_handover_grant", grant, 2'b10);
    check("t2_handover_s_adr", s_adr, 26'h24);
    tick();
    s_ack = 1'b0;
    m_drive(1, 0, 0, 0, '0, '0);
    tick();
    @(negedge clk);
    check("t2_idle_grant", grant, 2'b00);

    // Burst lock: m0 holds cyc over 4 reads while m1 waits.
    m_drive(0, 1, 1, 0, 26'h100, '0);
    tick();
    m_drive(1, 1, 1, 0, 26'h200, '0);
    for (int i = 0; i < 4; i++) begin
      m0_adr = 26'h100 + 26'(4 * i);
      s_rdat = 32'hB0000000 + 32'(i);
      sb.push_back('{0, 32'hB0000000 + 32'(i)});
      s_ack = 1'b1;
      @(negedge clk);
      check("t3_burst_grant", grant, 2'b01);
      check("t3_burst_adr", s_adr, 26'h100 + 26'(4 * i));
      tick();
    end
    s_ack = 1'b0;
    m_drive(0, 0, 0, 0, '0, '0);
    tick();
    s_rdat = 32'hC0DE0000;
    sb.push_back('{1, 32'hC0DE0000});
    s_ack = 1'b1;
    @(negedge clk);
    check("t3_after_grant", grant, 2'b10);
    tick();
    s_ack = 1'b0;
    m_drive(1, 0, 0, 0, '0, '0);
    tick();
    @(negedge clk);
    check("t3_idle_busy", busy, 1'b0);

    // Timeout: slave never acks.
    m_drive(0, 1, 1, 0, 26'h300, '0);
    tick();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("t4_stall_s_cyc", s_cyc, 1'b1);
      check("t4_stall_err", m0_err, 1'b0);
      tick();
    end
    @(negedge clk);
    check("t4_to_err", m0_err, 1'b1);
    check("t4_to_s_cyc", s_cyc, 1'b0);
    check("t4_to_s_stb", s_stb, 1'b0);
    check("t4_to_ack", m0_ack, 1'b0);
    check("t4_to_m1_err", m1_err, 1'b0);
    tick();
    m_drive(0, 0, 0, 0, '0, '0);
    @(negedge clk);
    check("t4_err_pulse", m0_err, 1'b0);
    check("t4_idle_grant", grant, 2'b00);
    tick();

    // Late acks: on the 4th stalled cycle and on the terminal-count cycle.
    for (int ack_at = 4; ack_at <= 5; ack_at++) begin
      m_drive(0, 1, 1, 0, 26'h400, '0);
      tick();
      for (int k = 1; k < ack_at; k++) begin
        @(negedge clk);
        check("t4b_stall_err", m0_err, 1'b0);
        tick();
      end
      s_rdat = 32'hD0 + 32'(ack_at);
      sb.push_back('{0, 32'hD0 + 32'(ack_at)});
      s_ack = 1'b1;
      @(negedge clk);
      check("t4b_late_ack", m0_ack, 1'b1);
      check("t4b_late_err", m0_err, 1'b0);
      check("t4b_late_s_cyc", s_cyc, 1'b1);
      tick();
      s_ack = 1'b0;
      m_drive(0, 0, 0, 0, '0, '0);
      tick();
    end

    // Asynchronous reset mid-burst in GNT1, then tie goes to m0.
    m_drive(1, 1, 1, 1, 26'h500, 32'h55);
    tick();
    @(negedge clk);
    check("t5_pre_grant", grant, 2'b10);
    #1;
    rst = 1'b1;
    #1;
    check("t5_rst_grant", grant, 2'b00);
    check("t5_rst_s_cyc", s_cyc, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_err", m1_err, 1'b0);
    #1;
    rst = 1'b0;
    m_drive(0, 1, 1, 0, 26'h600, '0);
    tick();
    @(negedge clk);
    check("t5_tie_grant", grant, 2'b01);
    tick();
    m_drive(0, 0, 0, 0, '0, '0);
    m_drive(1, 0, 0, 0, '0, '0);
    repeat (3) tick();

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_sdrc_arbiter.md
WB_SDRC_ARBITER -- requirements
Module: wb_sdrc_arbiter

Interface
REQ-001 SHALL have parameter AW, default 26, Wishbone address width.
REQ-002 SHALL have parameter DW, default 32, Wishbone data width; byte-select width DW/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, cycles without ack before error; legal range 2..65535.
REQ-004 SHALL have port wb_clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports m0_wb_cyc_i / m1_wb_cyc_i  input  1  master bus-cycle request.
REQ-007 SHALL have ports m0_wb_stb_i / m1_wb_stb_i  input  1  master strobe.
REQ-008 SHALL have ports m0_wb_we_i / m1_wb_we_i  input  1  master write enable.
REQ-009 SHALL have ports m0_wb_sel_i / m1_wb_sel_i  input  DW/8  master byte selects.
REQ-010 SHALL have ports m0_wb_adr_i / m1_wb_adr_i  input  AW  master address.
REQ-011 SHALL have ports m0_wb_dat_i / m1_wb_dat_i  input  DW  master write data.
REQ-012 SHALL have ports m0_wb_dat_o / m1_wb_dat_o  output  DW  read data, both driven from s_wb_dat_i.
REQ-013 SHALL have ports m0_wb_ack_o / m1_wb_ack_o  output  1  master acknowledge.
REQ-014 SHALL have ports m0_wb_err_o / m1_wb_err_o  output  1  master timeout error.
REQ-015 SHALL have ports s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  output  1 each  to SDRAM controller Wishbone port.
REQ-016 SHALL have ports s_wb_sel_o (DW/8), s_wb_adr_o (AW), s_wb_dat_o (DW)  output  to SDRAM controller.
REQ-017 SHALL have ports s_wb_dat_i (DW), s_wb_ack_i (1)  input  from SDRAM controller.
REQ-018 SHALL have port grant_o  output  2  registered one-hot grant; 2'b00 when idle.
REQ-019 SHALL have port busy_o  output  1  high when state is not IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, GNT0, GNT1; grant_o = 01 in GNT0, 10 in GNT1.
REQ-021 SHALL, in IDLE, move to GNTn next cycle when only mn_wb_cyc_i is high; slave request latency 1 cycle from cyc.
REQ-022 SHALL, in IDLE with both cyc high, grant the master not last granted (round-robin via 1-bit last_grant register).
REQ-023 SHALL hold grant while granted master's cyc stays high (burst lock); other master waits, no preemption.
REQ-024 SHALL, when granted cyc falls, go directly to other GNT state if other cyc is high (no dead cycle), else IDLE; last_grant updated on every grant.
REQ-025 SHALL drive s_wb_cyc_o/s_wb_stb_o = granted master's cyc/stb, combinationally; both 0 in IDLE.
REQ-026 SHALL mux we/sel/adr/dat from granted master; in IDLE drive zeros.
REQ-027 SHALL route s_wb_ack_i only to granted master's ack_o; non-granted ack_o/err_o = 0; ack_i in IDLE discarded.
REQ-028 SHALL count cycles where s_wb_stb_o=1 and s_wb_ack_i=0; counter clears on ack, on stb low, and on grant change.
REQ-029 SHALL, when counter reaches TIMEOUT, pulse granted mn_wb_err_o for exactly 1 cycle, force s_wb_cyc_o/stb_o to 0 that cycle, then apply REQ-024 as if cyc had fallen.
REQ-030 SHALL give ack priority over timeout when s_wb_ack_i arrives on the cycle count reaches TIMEOUT: ack passed, no err.
REQ-031 SHALL, if granted master drops cyc with stb pending, drop s_wb_cyc_o same cycle and ignore any later ack.
REQ-032 SHALL never assert both grant_o bits, nor ack_o and err_o on one master in the same cycle.

Reset
REQ-033 SHALL, on wb_rst_i high (asynchronous), force state IDLE, grant_o=00, busy_o=0, last_grant=M1 (M0 wins first tie), counter 0, all ack/err and s_wb_cyc_o/stb_o 0; reset mid-burst abandons transfer without err.

Verification
REQ-034 SHALL verify single master: m0 cyc/stb, write adr 0x10 dat 0xA5A5A5A5 -> s_wb_cyc_o high 1 cycle later, grant_o=01, m0_ack on s_wb_ack_i, m1_ack=0.
REQ-035 SHALL verify tie after reset: both cyc rise same cycle -> GNT0 first; m0 drops cyc with m1 still high -> GNT1 next cycle, no IDLE.
REQ-036 SHALL verify burst lock: m0 holds cyc over 4 acked reads while m1 requests -> grant_o stays 01 for all 4, then 10.
REQ-037 SHALL verify timeout with TIMEOUT=4: slave never acks -> m0_err 1 cycle after 4 stalled cycles, s_wb_cyc_o 0 that cycle; ack on 4th stalled cycle -> ack, no err.
REQ-038 SHALL verify async reset asserted mid-burst in GNT1 -> grant_o=00, s_wb_cyc_o=0 before next clock edge; after release tie goes to m0.
